// File: rtl/serial_2wire_arbiter.sv
// Round-robin transaction arbiter sharing one serial_2wire master between NUM_REQ requesters.
// Define SER_ARB_FIXED_PRIO_EN for fixed priority (lowest requesting index wins).
module serial_2wire_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned BITS           = 8,
  parameter int unsigned GRANT_WAIT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned IDX_BITS       = $clog2(NUM_REQ)
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [NUM_REQ-1:0]      in_req,
  output logic [NUM_REQ-1:0]      out_grant,
  input  logic [NUM_REQ-1:0]      in_enable,
  input  logic [NUM_REQ-1:0]      in_write,
  input  logic [NUM_REQ*BITS-1:0] in_addr,
  input  logic [NUM_REQ*BITS-1:0] in_parallel,
  output logic [NUM_REQ-1:0]      out_ready,
  output logic [NUM_REQ-1:0]      out_next_word,
  output logic [NUM_REQ-1:0]      out_err,
  output logic [BITS-1:0]         out_parallel,
  output logic                    out_busy,
  output logic [IDX_BITS-1:0]     out_owner,
  output logic                    out_ser_enable,
  output logic                    out_ser_write,
  output logic [BITS-1:0]         out_ser_addr,
  output logic [BITS-1:0]         out_ser_parallel,
  input  logic                    in_ser_ready,
  input  logic                    in_ser_next_word,
  input  logic                    in_ser_err,
  input  logic [BITS-1:0]         in_ser_parallel
);

  localparam int unsigned WdBits = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GwBits = $clog2(GRANT_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StActive, StRelease} state_e;

  state_e              state_q;
  logic [IDX_BITS-1:0] owner_q;
  logic [IDX_BITS-1:0] rr_ptr_q;
  logic [GwBits-1:0]   gw_q;
  logic [WdBits-1:0]   wd_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                wd_err_q;
  logic                nw_q;

  logic                owner_en;
  logic                owner_req;
  logic                nw_rise;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                pick_valid;
  logic [IDX_BITS-1:0] pick_idx;
  logic [IDX_BITS-1:0] next_ptr;
  logic [IDX_BITS-1:0] cand_idx;
  int unsigned         cand;

  assign owner_en   = in_enable[owner_q];
  assign owner_req  = in_req[owner_q];
  assign nw_rise    = in_ser_next_word & ~nw_q;
  assign owner_mask = NUM_REQ'(1) << owner_q;

`ifdef SER_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = (owner_q == IDX_BITS'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif

  // First requester at or after rr_ptr, wrapping cyclically.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_BITS'(cand);
      if (!pick_valid && in_req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      gw_q     <= '0;
      wd_q     <= '0;
      grant_q  <= '0;
      wd_err_q <= 1'b0;
      nw_q     <= 1'b0;
    end else begin
      nw_q     <= in_ser_next_word;
      wd_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid && in_ser_ready) begin
            owner_q <= pick_idx;
            grant_q <= NUM_REQ'(1) << pick_idx;
            gw_q    <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (owner_en) begin
            wd_q    <= '0;
            state_q <= StActive;
          end else if (!owner_req || gw_q == GwBits'(GRANT_WAIT - 1)) begin
            grant_q <= '0;
            state_q <= StRelease;
          end else begin
            gw_q <= gw_q + 1'b1;
          end
        end
        StActive: begin
          if (!owner_en) begin
            grant_q <= '0;
            state_q <= StRelease;
          end else if (nw_rise) begin
            wd_q <= '0;
          end else if (wd_q == WdBits'(TIMEOUT_CYCLES - 1)) begin
            // Stalled owner: reclaim the bus and flag it for one cycle.
            grant_q  <= '0;
            wd_err_q <= 1'b1;
            state_q  <= StRelease;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StRelease: begin
          if (in_ser_ready) begin
            rr_ptr_q <= next_ptr;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    out_ser_enable   = 1'b0;
    out_ser_write    = 1'b0;
    out_ser_addr     = '0;
    out_ser_parallel = '0;
    out_ready        = '0;
    out_next_word    = '0;
    out_err          = '0;
    out_parallel     = '0;
    if (state_q == StActive) begin
      out_ser_enable   = owner_en;
      out_ser_write    = in_write[owner_q];
      out_ser_addr     = in_addr[owner_q*BITS +: BITS];
      out_ser_parallel = in_parallel[owner_q*BITS +: BITS];
      out_ready        = owner_mask & {NUM_REQ{in_ser_ready}};
      out_next_word    = owner_mask & {NUM_REQ{in_ser_next_word}};
      out_err          = owner_mask & {NUM_REQ{in_ser_err}};
      out_parallel     = in_ser_parallel;
    end else if (state_q == StRelease) begin
      out_err = owner_mask & {NUM_REQ{wd_err_q}};
    end
  end

  assign out_grant = grant_q;
  assign out_busy  = (state_q != StIdle);
  assign out_owner = owner_q;

endmodule

// File: tb/tb_serial_2wire_arbiter.sv
// Directed bench for serial_2wire_arbiter: vector table for a basic transaction plus
// hand-written sequences for rotation, grant timeout, watchdog, reset and isolation.
module tb_serial_2wire_arbiter;

  logic        in_clk;
  logic        in_rst;
  logic [1:0]  in_req;
  logic [1:0]  out_grant;
  logic [1:0]  in_enable;
  logic [1:0]  in_write;
  logic [15:0] in_addr;
  logic [15:0] in_parallel;
  logic [1:0]  out_ready;
  logic [1:0]  out_next_word;
  logic [1:0]  out_err;
  logic [7:0]  out_parallel;
  logic        out_busy;
  logic [0:0]  out_owner;
  logic        out_ser_enable;
  logic        out_ser_write;
  logic [7:0]  out_ser_addr;
  logic [7:0]  out_ser_parallel;
  logic        in_ser_ready;
  logic        in_ser_next_word;
  logic        in_ser_err;
  logic [7:0]  in_ser_parallel;

  int checks = 0;
  int errors = 0;

  serial_2wire_arbiter #(
    .NUM_REQ       (2),
    .BITS          (8),
    .GRANT_WAIT    (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_req          (in_req),
    .out_grant       (out_grant),
    .in_enable       (in_enable),
    .in_write        (in_write),
    .in_addr         (in_addr),
    .in_parallel     (in_parallel),
    .out_ready       (out_ready),
    .out_next_word   (out_next_word),
    .out_err         (out_err),
    .out_parallel    (out_parallel),
    .out_busy        (out_busy),
    .out_owner       (out_owner),
    .out_ser_enable  (out_ser_enable),
    .out_ser_write   (out_ser_write),
    .out_ser_addr    (out_ser_addr),
    .out_ser_parallel(out_ser_parallel),
    .in_ser_ready    (in_ser_ready),
    .in_ser_next_word(in_ser_next_word),
    .in_ser_err      (in_ser_err),
    .in_ser_parallel (in_ser_parallel)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL time_limit got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] en;
    logic       rdy;
    logic       nw;
    logic [1:0] e_grant;
    logic       e_busy;
    logic       e_sen;
    logic [1:0] e_nw;
    logic [7:0] e_addr;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst           = 1'b0;
    in_req           = 2'b00;
    in_enable        = 2'b00;
    in_ser_ready     = 1'b1;
    in_ser_next_word = 1'b0;
    in_ser_err       = 1'b0;
    in_ser_parallel  = 8'h00;
    repeat (2) tick();
    in_rst = 1'b1;
    tick();
  endtask

  task automatic wait_grant();
    int n = 0;
    while (out_grant == 2'b00 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic run_txn(input logic [1:0] exp_g, input string nm);
    int n = 0;
    wait_grant();
    chk(nm, 32'(out_grant), 32'(exp_g));
    in_enable = out_grant;
    tick();
    in_ser_next_word = 1'b1;
    tick();
    in_ser_next_word = 1'b0;
    tick();
    in_enable = 2'b00;
    tick();
    while (out_busy && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int         cnt;
    logic       err_seen;
    logic [1:0] exp_g;

    in_write    = 2'b01;
    in_addr     = {8'h3C, 8'hA0};
    in_parallel = {8'hAA, 8'h55};
    do_reset();

    chk("rst_grant", 32'(out_grant), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_owner", 32'(out_owner), 32'd0);
    chk("rst_ser_en", 32'(out_ser_enable), 32'd0);

    // Single 3-word transaction from requester 0.
    //          req    en     rdy   nw    grant  busy  sen   nw_o   addr
    vecs[0]  = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00};
    vecs[1]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00};
    vecs[2]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 8'h00};
    vecs[3]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 8'h00};
    vecs[4]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'hA0};
    vecs[5]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'hA0};
    vecs[6]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'hA0};
    vecs[7]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'hA0};
    vecs[8]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 8'hA0};
    vecs[9]  = '{2'b01, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 8'hA0};
    vecs[10] = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 8'hA0};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00};
    vecs[12] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 8'h00};
    vecs[13] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00};

    for (int v = 0; v < 14; v++) begin
      in_req           = vecs[v].req;
      in_enable        = vecs[v].en;
      in_ser_ready     = vecs[v].rdy;
      in_ser_next_word = vecs[v].nw;
      #1;
      chk($sformatf("v%0d_grant", v), 32'(out_grant), 32'(vecs[v].e_grant));
      chk($sformatf("v%0d_busy", v), 32'(out_busy), 32'(vecs[v].e_busy));
      chk($sformatf("v%0d_ser_en", v), 32'(out_ser_enable), 32'(vecs[v].e_sen));
      chk($sformatf("v%0d_next_word", v), 32'(out_next_word), 32'(vecs[v].e_nw));
      chk($sformatf("v%0d_ser_addr", v), 32'(out_ser_addr), 32'(vecs[v].e_addr));
      tick();
    end

    // Both requesting continuously: rotation (or fixed priority).
    do_reset();
    in_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
`ifdef SER_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
      run_txn(exp_g, $sformatf("rr_grant%0d", t));
    end
    in_req = 2'b00;

    // Requester 1 granted but never enables.
    do_reset();
    in_req = 2'b10;
    wait_grant();
    chk("gw_grant", 32'(out_grant), 32'd2);
    cnt      = 0;
    err_seen = 1'b0;
    while (out_grant != 2'b00 && cnt < 40) begin
      cnt++;
      err_seen = err_seen | (|out_err);
      tick();
    end
    chk("gw_cycles", 32'(cnt), 32'd16);
    chk("gw_no_err", 32'(err_seen), 32'd0);
    in_req = 2'b11;
    wait_grant();
    chk("gw_rr_ptr", 32'(out_grant), 32'd1);
    in_req = 2'b00;

    // Watchdog on a stalled owner 0 while requester 1 waits.
    do_reset();
    in_req = 2'b11;
    wait_grant();
    chk("wd_grant", 32'(out_grant), 32'd1);
    in_enable    = 2'b01;
    in_ser_ready = 1'b0;
    tick();
    cnt = 0;
    while (out_ser_enable && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("wd_active_cycles", 32'(cnt), 32'd100);
    chk("wd_err_pulse", 32'(out_err), 32'd1);
    chk("wd_grant_off", 32'(out_grant), 32'd0);
    tick();
    chk("wd_err_clear", 32'(out_err), 32'd0);
    chk("wd_still_release", 32'(out_busy), 32'd1);
    in_enable    = 2'b00;
    in_ser_ready = 1'b1;
    tick();
    wait_grant();
`ifdef SER_ARB_FIXED_PRIO_EN
    chk("wd_next_grant", 32'(out_grant), 32'd1);
`else
    chk("wd_next_grant", 32'(out_grant), 32'd2);
`endif
    in_req = 2'b00;

    // Asynchronous reset in the middle of an active transaction of owner 1.
    do_reset();
    in_req = 2'b10;
    wait_grant();
    in_enable = 2'b10;
    tick();
    chk("ar_ser_en", 32'(out_ser_enable), 32'd1);
    chk("ar_owner", 32'(out_owner), 32'd1);
    #2;
    in_rst = 1'b0;
    #1;
    chk("ar_ser_en_drop", 32'(out_ser_enable), 32'd0);
    chk("ar_grant_drop", 32'(out_grant), 32'd0);
    chk("ar_owner_rst", 32'(out_owner), 32'd0);
    chk("ar_busy_rst", 32'(out_busy), 32'd0);
    in_enable = 2'b00;
    in_req    = 2'b11;
    tick();
    in_rst = 1'b1;
    wait_grant();
    chk("ar_first_grant", 32'(out_grant), 32'd1);
    in_req = 2'b00;

    // Non-owner activity during requester 0's transaction.
    do_reset();
    in_req = 2'b01;
    wait_grant();
    in_enable = 2'b01;
    tick();
    for (int i = 0; i < 6; i++) begin
      in_enable[1]        = i[0];
      in_req[1]           = i[0];
      in_write[1]         = ~i[0];
      in_addr[15:8]       = 8'(i * 37 + 5);
      in_parallel[15:8]   = 8'(i * 91 + 3);
      in_ser_ready        = 1'b1;
      in_ser_next_word    = i[0];
      in_ser_err          = i[0];
      in_ser_parallel     = 8'(8'h10 + i);
      #1;
      chk($sformatf("iso%0d_addr", i), 32'(out_ser_addr), 32'hA0);
      chk($sformatf("iso%0d_data", i), 32'(out_ser_parallel), 32'h55);
      chk($sformatf("iso%0d_write", i), 32'(out_ser_write), 32'd1);
      chk($sformatf("iso%0d_en", i), 32'(out_ser_enable), 32'd1);
      chk($sformatf("iso%0d_ready", i), 32'(out_ready), 32'd1);
      chk($sformatf("iso%0d_nw", i), 32'(out_next_word), 32'(i % 2));
      chk($sformatf("iso%0d_err", i), 32'(out_err), 32'(i % 2));
      chk($sformatf("iso%0d_rdata", i), 32'(out_parallel), 32'(16 + i));
      tick();
    end
    in_enable = 2'b00;
    in_req    = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
